ccff_chain_loader: RTL and testbench
====================================

# ccff_chain_loader

Configuration-chain loader that sits directly upstream of the I/O and logic tiles' `ccff_head` inputs. It accepts configuration words over a valid/ready port and serializes them MSB-first onto the chain, one bit per `prog_clk`. It generates the shift enable that gates the fabric's programming clock. At the same time it captures the previous chain contents emerging on `ccff_tail` as readback words.

## Interface

Parameters:
- `CHAIN_LEN`, default 1024: total configuration bits in the chain; must be at least 1.
- `WORD_W`, default 32: configuration and readback word width; must be at least 2.
- `CNT_W`, default `$clog2(CHAIN_LEN+1)`: width of the total-bit counter.

Ports:
- `prog_clk`, input, 1: programming clock.
- `pReset`, input, 1: asynchronous, active-high reset.
- `start`, input, 1: single-cycle request to begin a chain load.
- `word_data`, input, `WORD_W`: configuration word; bit `WORD_W-1` is shifted first.
- `word_valid`, input, 1: `word_data` is valid.
- `word_ready`, output, 1: the loader accepts a word this cycle.
- `ccff_head`, output, 1: serial data to the first tile's `ccff_head`.
- `ccff_shift_en`, output, 1: the chain shifts at the next `prog_clk` edge.
- `ccff_tail`, input, 1: serial data from the last tile's `ccff_tail`.
- `rb_word`, output, `WORD_W`: captured readback word.
- `rb_valid`, output, 1: single-cycle pulse; `rb_word` is valid.
- `busy`, output, 1: a load is in progress.
- `done`, output, 1: single-cycle pulse after the last chain bit has shifted.
- `crc`, output, 16: CRC of the emitted bits (see Configuration).

## Operation

States:
- IDLE
  - `busy`=0, `word_ready`=0, `ccff_shift_en`=0, `ccff_head`=0.
  - When `start`=1: clear the total-bit counter and the word-bit index, then go to LOAD.
- LOAD
  - `busy`=1, `word_ready`=1, `ccff_shift_en`=0.
  - On `word_valid & word_ready`: load the shift register with `word_data`, set the bit index to 0, then go to SHIFT.
- SHIFT
  - `ccff_shift_en`=1 and `ccff_head`=shift register MSB.
  - Every cycle: shift left by one, increment the bit index and the total counter, and shift `ccff_tail` into the readback register LSB.
  - When the bit index is `WORD_W-1` and more chain bits remain, `word_ready`=1 in that same cycle.
    - If a word is accepted, load it and stay in SHIFT. This gives back-to-back words with no bubble.
    - Otherwise go to LOAD. `ccff_shift_en` stays 0 until a word arrives, so the chain holds.
  - When the total counter reaches `CHAIN_LEN-1` (the last bit), go to DONE.
  - Any unshifted bits of the final word are discarded.
- DONE
  - `done`=1 for one cycle, `busy`=1, then go to IDLE.

Readback:
- `ccff_tail` is sampled at the same edge that shifts the chain, so the captured bits are the old contents. The first bit captured is the bit nearest the tail.
- After `WORD_W` captures, `rb_word` is updated and `rb_valid` pulses for one cycle.
- At chain end, a partial readback word is presented left-justified, with the unfilled LSBs set to 0, and `rb_valid` pulses.
- Readback has no back-pressure.

Boundary cases:
- `start` while `busy`=1 is ignored.
- `word_valid` outside a ready cycle is ignored.
- If `CHAIN_LEN` is a multiple of `WORD_W`, no ready is offered on the final bit.
- `pReset` asserted mid-load:
  - All outputs return to their reset values immediately.
  - The state returns to IDLE.
  - Chain contents are undefined, and the load must be restarted.

## Timing

Reset values:
- `word_ready`, `ccff_head`, `ccff_shift_en`, `rb_valid`, `busy` and `done` are 0.
- `rb_word` is 0.
- `crc` is 0xFFFF with the macro defined, otherwise 0x0000.
- State is IDLE.

Latency:
- `start` sampled at edge N puts the loader in LOAD (`word_ready`=1) from cycle N+1.
- A word accepted at edge M drives its MSB on `ccff_head` with `ccff_shift_en`=1 from cycle M+1.
- With no stalls, a load takes 1 + 1 + `CHAIN_LEN` + 1 cycles from `start` to the `done` pulse.

Ordering:
- `rb_valid` for the final word pulses in the DONE cycle.
- `ccff_head` and `ccff_shift_en` are decoded only from registered state.

## Configuration

`CCFF_LOADER_CRC_EN`:
- Defined:
  - A CRC-16-CCITT (polynomial 0x1021, MSB-first, no reflection) is initialised to 0xFFFF on an accepted `start`.
  - It is updated with each bit emitted on `ccff_head` in the cycles where `ccff_shift_en`=1.
  - `crc` holds its value through DONE and IDLE until the next `start`.
- Not defined: `crc` is the constant 0x0000 and no CRC logic is synthesized.

## Test plan

- `CHAIN_LEN`=40, `WORD_W`=32, words 0xA5A5A5A5 and 0xFF000000 presented immediately:
  - `ccff_head` emits 1010…0101 (32 bits) then 11111111.
  - `ccff_shift_en` is high for exactly 40 contiguous cycles.
  - `done` pulses 43 cycles after `start`.
- Same configuration with the second word delayed by 5 cycles:
  - `ccff_shift_en` drops for 5 cycles after bit 32, and `ccff_head` holds 0.
  - The total count of shift-enabled cycles is still 40.
- Model the chain as a 40-bit shift register preloaded with 0x12_3456_789A:
  - `rb_word`=0x12345678 after 32 shifts.
  - The final `rb_word`=0x9A000000.
  - The model chain then holds the loaded 40 bits.
- `start` pulsed while `busy`=1: ignored, and the bit count and `done` timing are unchanged.
- `pReset` asserted at shift bit 17:
  - All outputs go to 0 immediately.
  - After release and a new `start`, a full 40-bit load completes correctly.
- With `CCFF_LOADER_CRC_EN` defined, `CHAIN_LEN`=32, word 0x00000000: `crc` matches the reference CRC-16-CCITT of 32 zero bits starting from 0xFFFF. Without the macro, `crc` is 0x0000 throughout.

Source files
------------

// File: rtl/ccff_chain_loader.sv
// Configuration-chain loader: serialises words MSB-first onto ccff_head and captures readback from ccff_tail.
// Optional CRC-16-CCITT of the emitted bits is built only when CCFF_LOADER_CRC_EN is defined.
module ccff_chain_loader #(
    parameter int CHAIN_LEN = 1024,
    parameter int WORD_W    = 32,
    parameter int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
    input  logic              prog_clk,
    input  logic              pReset,
    input  logic              start,
    input  logic [WORD_W-1:0] word_data,
    input  logic              word_valid,
    output logic              word_ready,
    output logic              ccff_head,
    output logic              ccff_shift_en,
    input  logic              ccff_tail,
    output logic [WORD_W-1:0] rb_word,
    output logic              rb_valid,
    output logic              busy,
    output logic              done,
    output logic [15:0]       crc
);
    localparam int               IDX_W    = $clog2(WORD_W);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORD_W - 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(CHAIN_LEN - 1);

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_e;

    state_e            state_q, state_d;
    logic [WORD_W-1:0] sreg_q, sreg_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [CNT_W-1:0]  total_q, total_d;
    logic [WORD_W-1:0] rb_sh_q, rb_sh_d;
    logic [WORD_W-1:0] rb_word_q, rb_word_d;
    logic              rb_valid_q, rb_valid_d;
    logic              last_bit, word_end, accept;

    assign last_bit = (total_q == LAST_BIT);
    assign word_end = (idx_q == LAST_IDX);
    assign accept   = word_valid & word_ready;

    // NOTE: state registers use <= so every flop samples pre-edge values.
    always_ff @(posedge prog_clk or posedge pReset) begin
        if (pReset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = LOAD;
            LOAD:    if (word_valid) state_d = SHIFT;
            SHIFT: begin
                if (last_bit) begin
                    state_d = DONE;
                end else if (word_end && !word_valid) begin
                    state_d = LOAD;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Chain-facing strobes come purely from registered state so they are glitch-free.
    always_comb begin
        busy          = 1'b0;
        word_ready    = 1'b0;
        ccff_shift_en = 1'b0;
        ccff_head     = 1'b0;
        done          = 1'b0;
        case (state_q)
            LOAD: begin
                busy       = 1'b1;
                word_ready = 1'b1;
            end
            SHIFT: begin
                busy          = 1'b1;
                ccff_shift_en = 1'b1;
                ccff_head     = sreg_q[WORD_W-1];
                word_ready    = word_end & ~last_bit;
            end
            DONE: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: ;
        endcase
    end

    always_comb begin
        sreg_d     = sreg_q;
        idx_d      = idx_q;
        total_d    = total_q;
        rb_sh_d    = rb_sh_q;
        rb_word_d  = rb_word_q;
        rb_valid_d = 1'b0;
        if (state_q == IDLE && start) begin
            total_d = '0;
            idx_d   = '0;
        end
        if (ccff_shift_en) begin
            sreg_d  = sreg_q << 1;
            idx_d   = idx_q + 1'b1;
            total_d = total_q + 1'b1;
            rb_sh_d = {rb_sh_q[WORD_W-2:0], ccff_tail};
            if (word_end) begin
                rb_word_d  = rb_sh_d;
                rb_valid_d = 1'b1;
            end else if (last_bit) begin
                // Partial final word: left-justify the idx_q+1 captured bits.
                rb_word_d  = rb_sh_d << (LAST_IDX - idx_q);
                rb_valid_d = 1'b1;
            end
        end
        if (accept) begin
            sreg_d = word_data;
            idx_d  = '0;
        end
    end

    always_ff @(posedge prog_clk or posedge pReset) begin
        if (pReset) begin
            sreg_q     <= '0;
            idx_q      <= '0;
            total_q    <= '0;
            rb_sh_q    <= '0;
            rb_word_q  <= '0;
            rb_valid_q <= 1'b0;
        end else begin
            sreg_q     <= sreg_d;
            idx_q      <= idx_d;
            total_q    <= total_d;
            rb_sh_q    <= rb_sh_d;
            rb_word_q  <= rb_word_d;
            rb_valid_q <= rb_valid_d;
        end
    end

    assign rb_word  = rb_word_q;
    assign rb_valid = rb_valid_q;

`ifdef CCFF_LOADER_CRC_EN
    logic [15:0] crc_q, crc_d;
    logic        crc_fb;

    always_comb begin
        crc_d  = crc_q;
        crc_fb = crc_q[15] ^ ccff_head;
        if (state_q == IDLE && start) begin
            crc_d = 16'hFFFF;
        end else if (ccff_shift_en) begin
            crc_d = {crc_q[14:0], 1'b0} ^ (crc_fb ? 16'h1021 : 16'h0000);
        end
    end

    always_ff @(posedge prog_clk or posedge pReset) begin
        if (pReset) begin
            crc_q <= 16'hFFFF;
        end else begin
            crc_q <= crc_d;
        end
    end

    assign crc = crc_q;
`else
    assign crc = 16'h0000;
`endif

endmodule

// File: tb/tb_ccff_chain_loader.sv
// Scoreboard bench for ccff_chain_loader: a fabric chain model drives ccff_tail, expected
// head bits, readback words and done timing are queued at stimulus time and popped by a monitor.
module tb_ccff_chain_loader;
    localparam int CHAIN_LEN = 40;
    localparam int WORD_W    = 32;
    localparam int NWORDS    = (CHAIN_LEN + WORD_W - 1) / WORD_W;
    localparam logic [CHAIN_LEN-1:0] FAB_INIT = 40'h12_3456_789A;
`ifdef CCFF_LOADER_CRC_EN
    localparam logic [15:0] CRC_RST = 16'hFFFF;
`else
    localparam logic [15:0] CRC_RST = 16'h0000;
`endif

    typedef struct {
        int          cyc;
        logic [15:0] crc;
    } done_t;

    logic              prog_clk = 1'b0;
    logic              pReset = 1'b1;
    logic              start = 1'b0;
    logic [WORD_W-1:0] word_data = '0;
    logic              word_valid = 1'b0;
    logic              word_ready, ccff_head, ccff_shift_en, ccff_tail;
    logic [WORD_W-1:0] rb_word;
    logic              rb_valid, busy, done;
    logic [15:0]       crc;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int shift_cnt = 0;

    bit                chain_m[$];
    bit                head_q[$];
    logic [WORD_W-1:0] rb_q[$];
    done_t             done_q[$];

    logic [WORD_W-1:0] words[NWORDS];
    int                gaps[NWORDS];

    logic [CHAIN_LEN-1:0] fab_q = FAB_INIT;

    ccff_chain_loader #(.CHAIN_LEN(CHAIN_LEN), .WORD_W(WORD_W)) dut (
        .prog_clk(prog_clk), .pReset(pReset), .start(start),
        .word_data(word_data), .word_valid(word_valid), .word_ready(word_ready),
        .ccff_head(ccff_head), .ccff_shift_en(ccff_shift_en), .ccff_tail(ccff_tail),
        .rb_word(rb_word), .rb_valid(rb_valid), .busy(busy), .done(done), .crc(crc)
    );

    always #5 prog_clk = ~prog_clk;

    // Fabric model: the bit farthest from the head sits at the MSB and drives ccff_tail.
    assign ccff_tail = fab_q[CHAIN_LEN-1];
    always @(posedge prog_clk) if (ccff_shift_en) fab_q <= {fab_q[CHAIN_LEN-2:0], ccff_head};

    always @(posedge prog_clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

`ifdef CCFF_LOADER_CRC_EN
    function automatic logic [15:0] crc_step(input logic [15:0] c, input bit b);
        logic [15:0] sh;
        sh = {c[14:0], 1'b0};
        return (c[15] ^ b) ? (sh ^ 16'h1021) : sh;
    endfunction
`endif

    bit    mon_b;
    done_t mon_d;
    always @(negedge prog_clk) begin
        if (!pReset) begin
            if (ccff_shift_en) begin
                if (head_q.size() == 0) begin
                    check("shift_unexpected", 1, 0);
                end else begin
                    mon_b = head_q.pop_front();
                    check("ccff_head", ccff_head, mon_b);
                    void'(chain_m.pop_front());
                    chain_m.push_back(mon_b);
                end
                shift_cnt++;
            end else begin
                check("head_zero_when_idle", ccff_head, 0);
            end
            if (rb_valid) begin
                if (rb_q.size() == 0) check("rb_valid_unexpected", 1, 0);
                else check("rb_word", rb_word, rb_q.pop_front());
            end
            if (done) begin
                if (done_q.size() == 0) begin
                    check("done_unexpected", 1, 0);
                end else begin
                    mon_d = done_q.pop_front();
                    check("done_cycle", cyc, mon_d.cyc);
                    check("shift_count", shift_cnt, CHAIN_LEN);
                    check("rb_all_seen", rb_q.size(), 0);
                    check("crc_at_done", crc, mon_d.crc);
                end
            end
        end
    end

    task automatic send_word(input logic [WORD_W-1:0] w, input int gap);
        int g;
        bit ok;
        g  = gap;
        ok = 0;
        for (int t = 0; t < 200; t++) begin
            @(negedge prog_clk);
            if (word_ready) begin
                if (g == 0) begin
                    ok = 1;
                    break;
                end
                g--;
                word_valid = 1'b0;
            end else begin
                // Junk offered outside a ready cycle must be ignored.
                word_valid = ($urandom_range(0, 3) == 0);
                word_data  = $urandom;
            end
        end
        if (ok) begin
            word_data  = w;
            word_valid = 1'b1;
            @(posedge prog_clk);
            #1 word_valid = 1'b0;
        end else begin
            word_valid = 1'b0;
            check("word_ready_timeout", 0, 1);
        end
    endtask

    task automatic run_load(input bit dup_start, input int rst_at);
        bit                   bits[$];
        logic [15:0]          c;
        logic [WORD_W-1:0]    r;
        logic [CHAIN_LEN-1:0] exp_fab;
        int                   tot;
        bit                   idle_ok;
        done_t                d;

        for (int i = 0; i < NWORDS; i++)
            for (int j = WORD_W - 1; j >= 0; j--)
                if (bits.size() < CHAIN_LEN) bits.push_back(words[i][j]);
`ifdef CCFF_LOADER_CRC_EN
        c = 16'hFFFF;
        foreach (bits[k]) c = crc_step(c, bits[k]);
`else
        c = 16'h0000;
`endif
        for (int k = 0; k < CHAIN_LEN; k += WORD_W) begin
            r = '0;
            for (int j = 0; j < WORD_W; j++)
                if (k + j < CHAIN_LEN) r[WORD_W-1-j] = chain_m[k+j];
            rb_q.push_back(r);
        end
        tot = 0;
        foreach (gaps[i]) tot += gaps[i];

        @(negedge prog_clk);
        start     = 1'b1;
        shift_cnt = 0;
        foreach (bits[k]) head_q.push_back(bits[k]);
        d.cyc = cyc + CHAIN_LEN + 2 + tot;
        d.crc = c;
        done_q.push_back(d);
        @(posedge prog_clk);
        #1 start = 1'b0;

        if (rst_at >= 0) begin
            send_word(words[0], gaps[0]);
            repeat (rst_at) @(posedge prog_clk);
            #1 pReset = 1'b1;
            #1;
            check("rst_busy", busy, 0);
            check("rst_word_ready", word_ready, 0);
            check("rst_shift_en", ccff_shift_en, 0);
            check("rst_head", ccff_head, 0);
            check("rst_done", done, 0);
            check("rst_rb_valid", rb_valid, 0);
            check("rst_rb_word", rb_word, 0);
            check("rst_crc", crc, CRC_RST);
            head_q.delete();
            rb_q.delete();
            done_q.delete();
            repeat (3) @(negedge prog_clk);
            pReset = 1'b0;
            return;
        end

        fork
            begin
                for (int i = 0; i < NWORDS; i++) send_word(words[i], gaps[i]);
            end
            begin
                if (dup_start) begin
                    repeat ($urandom_range(3, 38)) @(negedge prog_clk);
                    start = 1'b1;
                    @(posedge prog_clk);
                    #1 start = 1'b0;
                end
            end
        join

        idle_ok = 0;
        for (int t = 0; t < 300; t++) begin
            @(negedge prog_clk);
            if (!busy && done_q.size() == 0) begin
                idle_ok = 1;
                break;
            end
        end
        check("load_completes", idle_ok, 1);
        for (int k = 0; k < CHAIN_LEN; k++) exp_fab[CHAIN_LEN-1-k] = bits[k];
        check("fabric_chain", fab_q, exp_fab);
        check("crc_hold_idle", crc, c);
        check("head_all_seen", head_q.size(), 0);
    endtask

    initial begin
        logic [CHAIN_LEN-1:0] init;
        init = FAB_INIT;
        for (int i = CHAIN_LEN - 1; i >= 0; i--) chain_m.push_back(init[i]);

        repeat (2) @(negedge prog_clk);
        check("reset_busy", busy, 0);
        check("reset_word_ready", word_ready, 0);
        check("reset_shift_en", ccff_shift_en, 0);
        check("reset_head", ccff_head, 0);
        check("reset_done", done, 0);
        check("reset_rb_valid", rb_valid, 0);
        check("reset_rb_word", rb_word, 0);
        check("reset_crc", crc, CRC_RST);
        pReset = 1'b0;
        repeat (2) @(negedge prog_clk);

        words[0] = 32'hA5A5_A5A5; words[1] = 32'hFF00_0000;
        gaps[0]  = 0;             gaps[1]  = 0;
        run_load(1'b0, -1);

        words[0] = $urandom; words[1] = $urandom;
        gaps[0]  = 0;        gaps[1]  = 5;
        run_load(1'b1, -1);

        words[0] = $urandom; words[1] = $urandom;
        gaps[0]  = 0;        gaps[1]  = 0;
        run_load(1'b0, 17);

        words[0] = $urandom; words[1] = $urandom;
        gaps[0]  = 2;        gaps[1]  = 0;
        run_load(1'b0, -1);

        for (int n = 0; n < 6; n++) begin
            foreach (words[i]) begin
                words[i] = $urandom;
                gaps[i]  = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 4)) : 0;
            end
            run_load($urandom_range(0, 1) == 1, -1);
        end

        repeat (3) @(negedge prog_clk);
        check("final_rb_queue_empty", rb_q.size(), 0);
        check("final_done_queue_empty", done_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d checks, %0d failures", n_checks, n_fail);
        $fatal(1, "watchdog expired");
    end

endmodule
